// File: rtl/addition_stage2_align.sv
// Floating-point add stage 2: orders operands by exponent and right-aligns the smaller mantissa one bit per cycle, collecting guard/round/sticky.
// Latency count+1 edges from accept; holds result in DONE until ready_in, accepts only in IDLE.
module addition_stage2_align #(
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [EXPO_WIDTH-1:0] exponent_a_in,
  input  logic [EXPO_WIDTH-1:0] exponent_b_in,
  input  logic [MENT_WIDTH:0]   mentissa_a_in,
  input  logic [MENT_WIDTH:0]   mentissa_b_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [EXPO_WIDTH-1:0] bigger_exponent_out,
  output logic [MENT_WIDTH:0]   bigger_mentissa_out,
  output logic [MENT_WIDTH:0]   aligned_mentissa_out,
  output logic                  guard_out,
  output logic                  round_out,
  output logic                  sticky_out,
  output logic                  swap_out
);

  // Beyond this many shifts every mantissa bit has already landed in sticky.
  localparam logic [EXPO_WIDTH-1:0] MAX_SHIFT = EXPO_WIDTH'(MENT_WIDTH + 3);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [EXPO_WIDTH-1:0] count_q, count_d;
  logic [EXPO_WIDTH-1:0] big_exp_q, big_exp_d;
  logic [MENT_WIDTH:0]   big_man_q, big_man_d;
  logic [MENT_WIDTH:0]   aligned_q, aligned_d;
  logic                  guard_q, guard_d;
  logic                  round_q, round_d;
  logic                  sticky_q, sticky_d;
  logic                  swap_q, swap_d;

  logic                  b_bigger;
  logic [EXPO_WIDTH-1:0] exp_diff;
  logic [EXPO_WIDTH-1:0] shift_cnt;

  always_comb begin
    b_bigger  = exponent_b_in > exponent_a_in;
    exp_diff  = b_bigger ? (exponent_b_in - exponent_a_in) : (exponent_a_in - exponent_b_in);
    shift_cnt = (exp_diff > MAX_SHIFT) ? MAX_SHIFT : exp_diff;
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    big_exp_d = big_exp_q;
    big_man_d = big_man_q;
    aligned_d = aligned_q;
    guard_d   = guard_q;
    round_d   = round_q;
    sticky_d  = sticky_q;
    swap_d    = swap_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          big_exp_d = b_bigger ? exponent_b_in : exponent_a_in;
          big_man_d = b_bigger ? mentissa_b_in : mentissa_a_in;
          aligned_d = b_bigger ? mentissa_a_in : mentissa_b_in;
          swap_d    = b_bigger;
          guard_d   = 1'b0;
          round_d   = 1'b0;
          sticky_d  = 1'b0;
          count_d   = shift_cnt;
          state_d   = (shift_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        aligned_d = aligned_q >> 1;
        guard_d   = aligned_q[0];
        round_d   = guard_q;
        sticky_d  = sticky_q | round_q;
        count_d   = count_q - 1'b1;
        if (count_q <= EXPO_WIDTH'(1)) state_d = DONE;
      end
      DONE: begin
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      big_exp_q <= '0;
      big_man_q <= '0;
      aligned_q <= '0;
      guard_q   <= 1'b0;
      round_q   <= 1'b0;
      sticky_q  <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      big_exp_q <= big_exp_d;
      big_man_q <= big_man_d;
      aligned_q <= aligned_d;
      guard_q   <= guard_d;
      round_q   <= round_d;
      sticky_q  <= sticky_d;
      swap_q    <= swap_d;
    end
  end

  assign ready_out            = (state_q == IDLE);
  assign valid_out            = (state_q == DONE);
  assign bigger_exponent_out  = big_exp_q;
  assign bigger_mentissa_out  = big_man_q;
  assign aligned_mentissa_out = aligned_q;
  assign guard_out            = guard_q;
  assign round_out            = round_q;
  assign sticky_out           = sticky_q;
  assign swap_out             = swap_q;

endmodule
